// File: rtl/game_pkg.sv
// Shared game definitions: direction encoding, tile ids, map size defaults,
// movement FSM states and a saturating counter helper.
package game_pkg;

  localparam int MAP_W_DEF = 11;
  localparam int MAP_H_DEF = 11;

  localparam logic [15:0] TILE_FLOOR  = 16'h0000;
  localparam logic [15:0] TILE_PLAYER = 16'h0001;
  localparam logic [15:0] TILE_WALL   = 16'h0002;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_REDRAW  = 3'd4
  } move_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/btn_edge_arb.sv
// Falling-edge detector for the four active-low buttons with fixed-priority
// selection: lowest index wins, remaining simultaneous presses are dropped.
module btn_edge_arb
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] btn_n_i,
  output logic       press_vld_o,
  output dir_e       press_dir_o
);

  logic [3:0] btn_prev_q;
  logic [3:0] press;

  // Previous button sample; all-released after reset so no spurious press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) btn_prev_q <= 4'hF;
    else       btn_prev_q <= btn_n_i;
  end

  assign press = btn_prev_q & ~btn_n_i;

  // Priority encode the press vector, index 0 (up) first.
  always_comb begin
    press_vld_o = |press;
    press_dir_o = DIR_UP;
    if (press[0])      press_dir_o = DIR_UP;
    else if (press[1]) press_dir_o = DIR_DOWN;
    else if (press[2]) press_dir_o = DIR_LEFT;
    else if (press[3]) press_dir_o = DIR_RIGHT;
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: turns button presses into single-tile moves,
// checks the target tile through map BRAM port B, updates the position and
// hands a redraw request to the renderer.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int          MAP_W   = MAP_W_DEF,
  parameter int          MAP_H   = MAP_H_DEF,
  parameter int          START_X = 1,
  parameter int          START_Y = 1,
  parameter logic [15:0] WALL_ID = TILE_WALL,
  parameter int          RD_LAT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  btn_n,
  output logic [18:0] map_addr,
  output logic        map_rd,
  input  logic [15:0] map_data,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic        redraw_req,
  input  logic        redraw_ack,
  output logic        blocked,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam logic [3:0] X_MAX    = 4'(MAP_W - 1);
  localparam logic [3:0] Y_MAX    = 4'(MAP_H - 1);
  localparam logic [3:0] X_RST    = 4'(START_X);
  localparam logic [3:0] Y_RST    = 4'(START_Y);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic        press_vld;
  dir_e        press_dir;

  move_state_e state_q, state_d;
  dir_e        dir_q, dir_d;
  logic        pend_vld_q, pend_vld_d;
  dir_e        pend_dir_q, pend_dir_d;
  logic [3:0]  tx_q, tx_d, ty_q, ty_d;
  logic [3:0]  px_q, px_d, py_q, py_d;
  logic [18:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        req_q, req_d;
  logic        blk_q, blk_d;
  logic [15:0] step_q, step_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [3:0]  tgt_x, tgt_y;
  logic        off_map;
  logic [18:0] addr_calc;

  btn_edge_arb u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .btn_n_i     (btn_n),
    .press_vld_o (press_vld),
    .press_dir_o (press_dir)
  );

  // Target tile for the latched direction, flagging moves that leave the map.
  always_comb begin
    tgt_x   = px_q;
    tgt_y   = py_q;
    off_map = 1'b0;
    case (dir_q)
      DIR_UP:    if (py_q == 4'd0)  off_map = 1'b1; else tgt_y = py_q - 4'd1;
      DIR_DOWN:  if (py_q == Y_MAX) off_map = 1'b1; else tgt_y = py_q + 4'd1;
      DIR_LEFT:  if (px_q == 4'd0)  off_map = 1'b1; else tgt_x = px_q - 4'd1;
      DIR_RIGHT: if (px_q == X_MAX) off_map = 1'b1; else tgt_x = px_q + 4'd1;
      default:   off_map = 1'b1;
    endcase
  end

  assign addr_calc = 19'(tgt_y) * 19'(MAP_W) + 19'(tgt_x);

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    px_d       = px_q;
    py_d       = py_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    req_d      = req_q;
    blk_d      = 1'b0;
    step_d     = step_q;
    cnt_d      = cnt_q;

    // While busy a press only refreshes the single pending slot.
    if (state_q != ST_IDLE && press_vld) begin
      pend_vld_d = 1'b1;
      pend_dir_d = press_dir;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          // Buffered move goes first; a simultaneous press takes its slot.
          dir_d      = pend_dir_q;
          state_d    = ST_CALC;
          pend_vld_d = press_vld;
          if (press_vld) pend_dir_d = press_dir;
        end else if (press_vld) begin
          dir_d   = press_dir;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (off_map) begin
          blk_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tx_d    = tgt_x;
          ty_d    = tgt_y;
          addr_d  = addr_calc;
          rd_d    = 1'b1;
          cnt_d   = 2'd0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == LAT_LAST) state_d = ST_CHECK;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      ST_CHECK: begin
        if (map_data == WALL_ID) begin
          blk_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          px_d    = tx_q;
          py_d    = ty_q;
          step_d  = sat_inc16(step_q);
          req_d   = 1'b1;
          state_d = ST_REDRAW;
        end
      end
      ST_REDRAW: begin
        if (redraw_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register; reset aborts any read or redraw in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Position, pending slot, BRAM interface and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dir_q      <= DIR_UP;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_UP;
      tx_q       <= X_RST;
      ty_q       <= Y_RST;
      px_q       <= X_RST;
      py_q       <= Y_RST;
      addr_q     <= 19'd0;
      rd_q       <= 1'b0;
      req_q      <= 1'b0;
      blk_q      <= 1'b0;
      step_q     <= 16'd0;
      cnt_q      <= 2'd0;
    end else begin
      dir_q      <= dir_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      px_q       <= px_d;
      py_q       <= py_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      req_q      <= req_d;
      blk_q      <= blk_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
    end
  end

  assign map_addr   = addr_q;
  assign map_rd     = rd_q;
  assign player_x   = px_q;
  assign player_y   = py_q;
  assign redraw_req = req_q;
  assign blocked    = blk_q;
  assign busy       = (state_q != ST_IDLE);
  assign step_count = step_q;

endmodule
